// File: rtl/counter_7seg_mux.sv
// Multi-digit BCD/hex up/down counter with a time-multiplexed, active-low
// seven-segment driver that scans one digit at a time onto a shared bus.
module counter_7seg_mux #(
    parameter int DIGITS   = 4,
    parameter int HEX      = 0,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [6:0]            dout,
    output logic [DIGITS-1:0]     an
);

    localparam int         SW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int         IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0] MAXD = (HEX != 0) ? 4'hF : 4'h9;

    logic [SW-1:0]       scan_cnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] step_val;
    logic [4*DIGITS-1:0] load_fix;
    logic                all_max;
    logic                all_zero;
    logic                carry;
    logic [3:0]          digit;
    logic [3:0]          cur;

    // Ripple carry/borrow through the digits; the wrap flags fall out of the same walk.
    always_comb begin
        step_val = count;
        load_fix = load_val;
        all_max  = 1'b1;
        all_zero = 1'b1;
        carry    = 1'b1;
        digit    = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = count[4*i +: 4];
            if (digit != MAXD) all_max = 1'b0;
            if (digit != 4'h0) all_zero = 1'b0;
            if (carry) begin
                if (up) begin
                    if (digit == MAXD) begin
                        step_val[4*i +: 4] = 4'h0;
                    end else begin
                        step_val[4*i +: 4] = digit + 4'h1;
                        carry = 1'b0;
                    end
                end else begin
                    if (digit == 4'h0) begin
                        step_val[4*i +: 4] = MAXD;
                    end else begin
                        step_val[4*i +: 4] = digit - 4'h1;
                        carry = 1'b0;
                    end
                end
            end
            if (HEX == 0 && load_val[4*i +: 4] > 4'h9) load_fix[4*i +: 4] = 4'h9;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_fix;
            wrap  <= 1'b0;
        end else if (en) begin
            count <= step_val;
            wrap  <= up ? all_max : all_zero;
        end else begin
            wrap  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        cur = 4'h0;
        an  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur   = count[4*i +: 4];
                an[i] = 1'b0;
            end
        end
        case (cur)
            4'h0:    dout = 7'b1000000;
            4'h1:    dout = 7'b1111001;
            4'h2:    dout = 7'b0100100;
            4'h3:    dout = 7'b0110000;
            4'h4:    dout = 7'b0011001;
            4'h5:    dout = 7'b0010010;
            4'h6:    dout = 7'b0000010;
            4'h7:    dout = 7'b1111000;
            4'h8:    dout = 7'b0000000;
            4'h9:    dout = 7'b0010000;
            4'hA:    dout = 7'b0001000;
            4'hB:    dout = 7'b0000011;
            4'hC:    dout = 7'b1000110;
            4'hD:    dout = 7'b0100001;
            4'hE:    dout = 7'b0000110;
            default: dout = 7'b0001110;
        endcase
    end

endmodule

// File: doc/counter_7seg_mux.md
# counter_7seg_mux

Parametrised multi-digit up/down counter with a time-multiplexed seven-segment display driver, for the board display path. It holds a DIGITS-wide BCD or hex count with synchronous load, enable and direction control, and flags a full-range wrap. It scans the digits onto a single active-low segment bus with active-low digit enables, so one shared display can show the whole count.

## Interface
- DIGITS, 4: number of 4-bit digits (1..8).
- HEX, 0: 0 = BCD digits (0..9), 1 = hex digits (0..F).
- SCAN_DIV, 1000: clk cycles each digit is shown per scan slot (>=1).
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  count enable; one step per clk while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous load of load_val.
- load_val  in  4*DIGITS  value to load; digit i is bits [4i+3:4i].
- count  out  4*DIGITS  current count; digit 0 is least significant.
- wrap  out  1  one-cycle pulse on full-range wrap.
- dout  out  7  active-low segments {g,f,e,d,c,b,a} for the digit currently selected.
- an  out  DIGITS  active-low one-hot digit select.

## Operation
- Reset (rst=0, asynchronous, takes effect immediately):
  - count=0, wrap=0.
  - scan counter=0, digit index=0.
  - an = all ones except an[0]=0.
  - dout=1000000.
- Per rising edge, with priority load > en:
  - load=1: each digit takes load_val. In BCD mode a digit >9 is stored as 9. wrap=0. en and up are ignored.
  - load=0, en=1, up=1: digit 0 increments. A digit at MAX (9 in BCD, F in hex) becomes 0 and carries into the next digit.
  - load=0, en=1, up=0: digit 0 decrements. A digit at 0 becomes MAX and borrows from the next digit.
  - load=0, en=0: count holds, wrap=0.
- wrap is 1 for exactly the cycle after either full-range transition:
  - all digits MAX, counting up, to all 0.
  - all 0, counting down, to all MAX.
  - Otherwise wrap is 0.
- Scan:
  - The scan counter runs 0..SCAN_DIV-1 continuously, independent of en and load.
  - When it reaches SCAN_DIV-1, it returns to 0 and the digit index advances (DIGITS-1 wraps to 0).
  - an[i]=0 if and only if index==i.
- dout is decoded from digit[index] of the registered count (active-low):
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0010000, A:0001000, b:0000011
  - C:1000110, d:0100001, E:0000110, F:0001110
- DIGITS=1: an is permanently 0, and the index never changes.

## Timing
- count, wrap, scan counter and index are registers. dout and an are combinational from registers only; there is no input-to-output combinational path.
- Count latency: a load or step sampled at edge N is visible on count immediately after edge N.
- wrap is registered with the count, so it is high in the same cycle the wrapped value appears, for one cycle only.
- Each digit is selected for exactly SCAN_DIV clocks. A full scan takes DIGITS*SCAN_DIV clocks.
- dout follows a count change within the same cycle if the changed digit is selected.
- Reset released mid-scan restarts scanning at digit 0 with the scan counter at 0.
- Reset asserted mid-count clears count and wrap at once, regardless of clk.

## Test plan
All cases use DIGITS=4, HEX=0, SCAN_DIV=4 unless stated.
1. Assert rst=0, then release -> count=0000, wrap=0, an=1110, dout=1000000; scan has not advanced before the first post-reset edge.
2. load 0x0999 for 1 clk, then en=1, up=1 for 1 clk -> count=0x1000, wrap=0. load 0x9999, then 1 up step -> count=0x0000, wrap=1 for exactly 1 cycle.
3. From count=0000 (reset), en=1, up=0 for 1 clk -> count=9999, wrap pulse. With HEX=1, the same stimulus -> FFFF with a wrap pulse, and a further up step -> 0000 with a wrap pulse.
4. load_val=0x00A5, load=1, en=1, up=1 in the same cycle -> count=0x0095: the load wins and digit A is clamped to 9. The next cycle with en=0 -> the count holds.
5. load 0x1234, en=0, observe 16 clocks:
   - an=1110 with dout=0011001 ("4") for 4 clocks
   - an=1101 with dout=0110000 ("3") for 4 clocks
   - an=1011 with dout=0100100 ("2") for 4 clocks
   - an=0111 with dout=1111001 ("1") for 4 clocks
   - then an=1110 again.
6. Counting up continuously with en=1, assert rst=0 between edges -> count, wrap and an reset immediately. After release, counting resumes from 0001 at the first enabled edge.
